instr_fetch_seq: RTL and testbench

- Byte-serial instruction fetch sequencer for the multicycle 8-bit-memory MIPS core.
- Sits directly upstream of the control unit.
- On a start pulse it reads four consecutive bytes over a req/ack memory handshake and assembles them little-endian: byte k goes to instr[8k+7:8k].
- It then presents the word, op and funct atomically, with a one-cycle valid pulse that the control unit decodes.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/instr_fetch_seq.sv | 135 +++++++++++++
 tb/tb_instr_fetch_seq.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle 8-bit-memory MIPS core: opcodes,
// word/byte widths and the instruction fetch state encoding.
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam int BYTE_W  = 8;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_seq.sv
// Byte-serial instruction fetch: reads four bytes little-endian over a
// req/ack handshake and publishes the assembled word with a one-cycle valid.
module instr_fetch_seq
    import mips_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [BYTE_W-1:0] mem_rdata_i,
    output logic [3:0]        byte_sel_o,
    output logic              busy_o,
    output logic              instr_valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [5:0]        op_o,
    output logic [5:0]        funct_o,
    output logic              err_o
);

    localparam int WCNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    fetch_state_t       r_state;
    fetch_state_t       w_next;
    logic [ADDR_W-1:0]  r_base;
    logic [1:0]         r_k;
    logic [WCNT_W-1:0]  r_wcnt;
    logic [INSTR_W-1:0] r_shadow;
    logic [INSTR_W-1:0] r_instr;
    logic               w_timeout;

    // Fires in the TIMEOUT-th consecutive cycle without an ack on one byte.
    assign w_timeout = (TIMEOUT != 0) && (r_state == FETCH) && !mem_ack_i &&
                       (r_wcnt == WCNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_next = FETCH;
                end
            end
            FETCH: begin
                if (mem_ack_i && (r_k == 2'd3)) begin
                    w_next = DONE;
                end else if (w_timeout) begin
                    w_next = IDLE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        mem_req_o     = 1'b0;
        mem_addr_o    = '0;
        byte_sel_o    = 4'b0000;
        busy_o        = 1'b0;
        instr_valid_o = 1'b0;
        err_o         = 1'b0;
        case (r_state)
            FETCH: begin
                mem_req_o  = 1'b1;
                mem_addr_o = r_base + ADDR_W'(r_k);
                byte_sel_o = 4'b0001 << r_k;
                busy_o     = 1'b1;
                err_o      = w_timeout;
            end
            DONE: begin
                busy_o        = 1'b1;
                instr_valid_o = 1'b1;
            end
            default: ;
        endcase
    end

    // The published word is loaded on the final ack so it is already visible
    // in the DONE cycle; the shadow keeps partial words away from instr_o.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_base   <= '0;
            r_k      <= 2'd0;
            r_wcnt   <= '0;
            r_shadow <= '0;
            r_instr  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_base   <= pc_i;
                        r_k      <= 2'd0;
                        r_wcnt   <= '0;
                        r_shadow <= '0;
                    end
                end
                FETCH: begin
                    if (mem_ack_i) begin
                        r_shadow[{r_k, 3'b000} +: BYTE_W] <= mem_rdata_i;
                        r_wcnt <= '0;
                        if (r_k == 2'd3) begin
                            r_instr <= {mem_rdata_i, r_shadow[23:0]};
                        end else begin
                            r_k <= r_k + 2'd1;
                        end
                    end else if (w_timeout) begin
                        r_wcnt <= '0;
                    end else if (TIMEOUT != 0) begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign instr_o = r_instr;
    assign op_o    = r_instr[31:26];
    assign funct_o = r_instr[5:0];

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench for instr_fetch_seq: byte memory with per-lane ack delays,
// cycle-by-cycle checks of request, address, lane and publish timing.
module tb_instr_fetch_seq;
    import mips_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [7:0]  pc_i;
    logic        mem_req_o;
    logic [7:0]  mem_addr_o;
    logic        mem_ack_i;
    logic [7:0]  mem_rdata_i;
    logic [3:0]  byte_sel_o;
    logic        busy_o;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [5:0]  op_o;
    logic [5:0]  funct_o;
    logic        err_o;

    logic [7:0]  mem [256];
    int          delay_lane [4];
    int          waited;
    int          lane;
    int          total = 0;
    int          bad = 0;

    instr_fetch_seq #(.ADDR_W(8), .TIMEOUT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .pc_i(pc_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
        .mem_rdata_i(mem_rdata_i), .byte_sel_o(byte_sel_o), .busy_o(busy_o),
        .instr_valid_o(instr_valid_o), .instr_o(instr_o), .op_o(op_o),
        .funct_o(funct_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    always_comb begin
        lane = 0;
        if (byte_sel_o[1]) lane = 1;
        if (byte_sel_o[2]) lane = 2;
        if (byte_sel_o[3]) lane = 3;
        mem_ack_i   = mem_req_o && (waited >= delay_lane[lane]);
        mem_rdata_i = mem[mem_addr_o];
    end

    always @(posedge clk_i) begin
        if (mem_req_o && !mem_ack_i) waited <= waited + 1;
        else waited <= 0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_delays(input int d0, input int d1, input int d2, input int d3);
        delay_lane[0] = d0; delay_lane[1] = d1; delay_lane[2] = d2; delay_lane[3] = d3;
    endtask

    // Pulse start for one edge; returns at the sample point of cycle 1.
    task automatic launch(input logic [7:0] pc);
        @(negedge clk_i);
        start_i = 1'b1;
        pc_i    = pc;
        @(negedge clk_i);
        start_i = 1'b0;
        pc_i    = 8'h55;
    endtask

    // Walks a whole fetch from cycle 1, checking every request cycle and the
    // publish cycle. With inject set, start pulses with another pc in cycle 2
    // and in the DONE cycle.
    task automatic run_fetch(input string tag, input logic [7:0] pc,
                             input logic [31:0] exp_word, input bit inject);
        int cyc;
        cyc = 1;
        launch(pc);
        for (int k = 0; k < 4; k++) begin
            for (int d = 0; d <= delay_lane[k]; d++) begin
                chk({tag, "_req"}, {31'd0, mem_req_o}, 32'd1);
                chk({tag, "_addr"}, {24'd0, mem_addr_o}, {24'd0, 8'(pc + k)});
                chk({tag, "_sel"}, {28'd0, byte_sel_o}, {28'd0, 4'b0001 << k});
                chk({tag, "_vld_early"}, {31'd0, instr_valid_o}, 32'd0);
                start_i = inject && (cyc == 2);
                pc_i    = 8'h40;
                @(negedge clk_i);
                start_i = 1'b0;
                cyc++;
            end
        end
        chk({tag, "_vld"}, {31'd0, instr_valid_o}, 32'd1);
        chk({tag, "_busy_done"}, {31'd0, busy_o}, 32'd1);
        chk({tag, "_req_done"}, {31'd0, mem_req_o}, 32'd0);
        chk({tag, "_instr"}, instr_o, exp_word);
        chk({tag, "_op"}, {26'd0, op_o}, {26'd0, exp_word[31:26]});
        chk({tag, "_funct"}, {26'd0, funct_o}, {26'd0, exp_word[5:0]});
        start_i = inject;
        pc_i    = 8'h40;
        @(negedge clk_i);
        start_i = 1'b0;
        chk({tag, "_vld_after"}, {31'd0, instr_valid_o}, 32'd0);
        chk({tag, "_busy_after"}, {31'd0, busy_o}, 32'd0);
        chk({tag, "_req_after"}, {31'd0, mem_req_o}, 32'd0);
        @(negedge clk_i);
        chk({tag, "_idle2"}, {31'd0, mem_req_o | instr_valid_o}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'hA5);
        mem[8'h10] = 8'h20; mem[8'h11] = 8'h00; mem[8'h12] = 8'h08; mem[8'h13] = 8'h8C;
        mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33; mem[8'h01] = 8'h44;
        set_delays(0, 0, 0, 0);
        rst_i   = 1'b0;
        start_i = 1'b0;
        pc_i    = 8'h00;
        #2;
        chk("rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_sel", {28'd0, byte_sel_o}, 32'd0);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_err", {31'd0, err_o | instr_valid_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // zero-wait fetch
        run_fetch("zw", 8'h10, 32'h8C080020, 1'b0);
        chk("zw_op_lw", {26'd0, op_o}, {26'd0, OP_LW});
        chk("zw_funct20", {26'd0, funct_o}, 32'h20);

        // three wait states on byte 1
        set_delays(0, 3, 0, 0);
        run_fetch("ws", 8'h10, 32'h8C080020, 1'b0);

        // address wrap
        set_delays(0, 0, 0, 0);
        run_fetch("wrap", 8'hFE, 32'h44332211, 1'b0);

        // timeout on byte 2: requests in cycles 3..6, err in cycle 6
        set_delays(0, 0, 1000, 0);
        launch(8'h20);
        for (int c = 1; c <= 6; c++) begin
            chk("to_req", {31'd0, mem_req_o}, 32'd1);
            chk("to_err", {31'd0, err_o}, {31'd0, c == 6});
            if (c >= 3) chk("to_addr", {24'd0, mem_addr_o}, 32'h22);
            @(negedge clk_i);
        end
        chk("to_req_low", {31'd0, mem_req_o}, 32'd0);
        chk("to_busy_low", {31'd0, busy_o}, 32'd0);
        chk("to_err_once", {31'd0, err_o}, 32'd0);
        chk("to_no_vld", {31'd0, instr_valid_o}, 32'd0);
        chk("to_instr_kept", instr_o, 32'h44332211);

        // start while busy
        set_delays(0, 0, 0, 0);
        run_fetch("busy", 8'h10, 32'h8C080020, 1'b1);

        // async reset during byte 2
        launch(8'hFE);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("ar_pre_addr", {24'd0, mem_addr_o}, 32'h00);
        #2;
        rst_i = 1'b0;
        #1;
        chk("ar_req", {31'd0, mem_req_o}, 32'd0);
        chk("ar_busy", {31'd0, busy_o}, 32'd0);
        chk("ar_sel", {28'd0, byte_sel_o}, 32'd0);
        chk("ar_instr", instr_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        run_fetch("post_rst", 8'h10, 32'h8C080020, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
